// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Word-addressed data memory behind the processor's MemRead/MemWrite controls.
//   It takes one load or store at a time. The request is captured in IDLE, waits
//   LATENCY cycles in BUSY, and then completes with a one-cycle ready pulse in RESP.
//   A misaligned request, or one with both MemRead and MemWrite set, waits the full
//   latency and then answers with err=1 and makes no memory access.
//   Optional feature macro: DMEM_STATS_EN adds the saturating rd_count/wr_count
//   counters for completed loads and stores.
module data_memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2   // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic                    is_load_q;
  logic                    is_store_q;
  logic                    bad_q;
  logic                    request;
  logic                    access_en;
  logic                    load_ok;
  logic                    store_ok;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign request   = MemRead | MemWrite;
  assign access_en = (state_q == BUSY) && (cnt_q == 4'd0);
  assign load_ok   = is_load_q  & ~bad_q;
  assign store_ok  = is_store_q & ~bad_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> BUSY on a request, BUSY -> RESP when the count runs out.
  always_comb begin
    // NOTE: a default value on every path keeps this block from inferring a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (request)          state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0)    state_d = RESP;
      RESP:                          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Capture the request in IDLE and count the latency down in BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      bad_q      <= 1'b0;
    end else if (state_q == IDLE && request) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      cnt_q      <= CNT_INIT;
      idx_q      <= addr[ADDR_WIDTH+1:2];
      wdata_q    <= wdata;
      is_load_q  <= MemRead & ~MemWrite;
      is_store_q <= MemWrite & ~MemRead;
      bad_q      <= (MemRead & MemWrite) | (addr[1:0] != 2'b00);
    end else if (state_q == BUSY && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Memory access on the edge entering RESP; a reset in that cycle cancels the write.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset, so it maps onto plain RAM and keeps its contents.
    if (!reset && access_en) begin
      if (store_ok) mem[idx_q] <= wdata_q;
      if (load_ok)  rd_q       <= mem[idx_q];
    end
  end

  // Outputs: ready and err exist only in RESP, and rdata is zero except for a good load.
  always_comb begin
    ready = (state_q == RESP);
    err   = (state_q == RESP) & bad_q;
    rdata = ((state_q == RESP) && load_ok) ? rd_q : '0;
  end

`ifdef DMEM_STATS_EN
  // Completed-load and completed-store counters. Error responses are not counted,
  // and each counter stops at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (state_q == RESP) begin
      if (load_ok  && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (store_ok && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
//   Randomised and directed load/store traffic. The bench keeps a word-array model
//   and a queue of expected responses, each tagged with the cycle of its ready pulse.
//   A single compare process checks ready/err/rdata on every falling edge.
//   Build with DMEM_STATS_EN defined to exercise the counters as well.
module tb_data_memory_responder;

  localparam int DW      = 32;
  localparam int AW      = 8;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemRead;
  logic          MemWrite;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          err;
`ifdef DMEM_STATS_EN
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;
`endif

  data_memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LATENCY)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err)
`ifdef DMEM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en = 1'b0;
  exp_t        expq[$];
  logic [31:0] model [DEPTH];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare process: outside a scheduled response cycle every output must be zero.
  always @(negedge clk) begin
    if (chk_en) begin
      logic        er;
      logic        ee;
      logic [31:0] ed;
      er = 1'b0;
      ee = 1'b0;
      ed = '0;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        er = 1'b1;
        ee = expq[0].err;
        ed = expq[0].data;
        void'(expq.pop_front());
      end
      check("ready", 32'(ready), 32'(er));
      check("err",   32'(err),   32'(ee));
      check("rdata", rdata,      ed);
    end
  end

  // Issue one transaction, log its expected response, and hold it until ready.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got_d, output logic got_e, output int lat);
    int          cap;
    int          idx;
    logic        bad;
    logic [31:0] exp_d;
    exp_t        e;
    @(negedge clk);
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    cap      = cyc + 1;
    idx      = int'((a >> 2) % DEPTH);
    bad      = (rd && wr) || (a[1:0] != 2'b00);
    exp_d    = '0;
    if (!bad && wr) model[idx] = d;
    if (!bad && rd) exp_d = model[idx];
    e.cyc  = cap + LATENCY;
    e.err  = bad;
    e.data = exp_d;
    expq.push_back(e);
    got_d = '0;
    got_e = 1'b0;
    lat   = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cyc == cap) begin
        addr  = $urandom;   // post-capture changes must be ignored
        wdata = $urandom;
      end
      if (ready) begin
        got_d = rdata;
        got_e = err;
        lat   = cyc - cap + 1;
        break;
      end
    end
    if (lat < 0) check("ready_timeout", 32'd0, 32'd1);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  logic [31:0] gd;
  logic        ge;
  int          lat;

  initial begin
    reset    = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = '0;
    wdata    = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    reset = 1'b0;

    // Give every word a known value so later loads are predictable.
    for (int i = 0; i < DEPTH; i++)
      do_txn(1'b0, 1'b1, 32'(i) << 2, 32'hC0DE_0000 | 32'(i), gd, ge, lat);

    // Store then load @0x10, three cycles from capture to ready.
    do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, gd, ge, lat);
    check("store_latency", 32'(lat), 32'd3);
    check("store_err", 32'(ge), 32'd0);
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, gd, ge, lat);
    check("load_latency", 32'(lat), 32'd3);
    check("load_data", gd, 32'hDEADBEEF);

    // A misaligned load returns err and no data, and leaves the memory unchanged.
    do_txn(1'b1, 1'b0, 32'h13, 32'h0, gd, ge, lat);
    check("misaligned_err", 32'(ge), 32'd1);
    check("misaligned_rdata", gd, 32'd0);
    check("misaligned_latency", 32'(lat), 32'd3);
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, gd, ge, lat);
    check("after_misaligned", gd, 32'hDEADBEEF);

    // Both controls high is rejected and does not write.
    do_txn(1'b1, 1'b1, 32'h20, 32'h55, gd, ge, lat);
    check("both_err", 32'(ge), 32'd1);
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, gd, ge, lat);
    check("both_nowrite", gd, 32'hC0DE_0008);

    // Addresses alias: 0x400 selects word 0.
    do_txn(1'b0, 1'b1, 32'h400, 32'hA5, gd, ge, lat);
    do_txn(1'b1, 1'b0, 32'h000, 32'h0, gd, ge, lat);
    check("alias", gd, 32'hA5);

    // A reset in the last BUSY cycle aborts the store, and no ready follows.
    @(negedge clk);
    MemWrite = 1'b1;
    addr     = 32'h40;
    wdata    = 32'h1234;
    @(negedge clk);
    MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    do_txn(1'b1, 1'b0, 32'h40, 32'h0, gd, ge, lat);
    check("abort_nowrite", gd, 32'hC0DE_0010);

    // A reset in the same cycle as a request wins, and nothing is captured.
    @(negedge clk);
    reset   = 1'b1;
    MemRead = 1'b1;
    addr    = 32'h10;
    @(negedge clk);
    reset   = 1'b0;
    MemRead = 1'b0;
    repeat (6) @(negedge clk);

    // A request held into the IDLE cycle after RESP is captured again.
    begin
      exp_t e;
      do_txn(1'b1, 1'b0, 32'h10, 32'h0, gd, ge, lat);
      MemRead = 1'b1;
      addr    = 32'h10;
      e.cyc  = cyc + 2 + LATENCY;
      e.err  = 1'b0;
      e.data = 32'hDEADBEEF;
      expq.push_back(e);
      @(negedge clk);
      @(negedge clk);
      MemRead = 1'b0;
      repeat (LATENCY + 3) @(negedge clk);
    end

    // Random traffic, including aliasing, misaligned and both-high requests.
    for (int n = 0; n < 300; n++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 7));
      a  = {$urandom_range(0, 32'h3F_FFFF), 10'h0} | (32'($urandom_range(0, DEPTH - 1)) << 2);
      if (op == 7) a[1:0] = 2'($urandom_range(1, 3));
      do_txn(op <= 2 || op >= 6, (op >= 3 && op <= 5) || op == 6 || (op == 7 && a[2]),
             a, $urandom, gd, ge, lat);
    end

`ifdef DMEM_STATS_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) do_txn(1'b1, 1'b0, 32'(i) << 2, 32'h0, gd, ge, lat);
    for (int i = 0; i < 2; i++) do_txn(1'b0, 1'b1, 32'(i) << 2, 32'h77, gd, ge, lat);
    do_txn(1'b1, 1'b0, 32'h6, 32'h0, gd, ge, lat);
    repeat (2) @(negedge clk);
    check("rd_count", 32'(rd_count), 32'd3);
    check("wr_count", 32'(wr_count), 32'd2);
    force dut.wr_count = 16'hFFFF;
    @(negedge clk);
    release dut.wr_count;
    do_txn(1'b0, 1'b1, 32'h8, 32'h99, gd, ge, lat);
    repeat (2) @(negedge clk);
    check("wr_count_sat", 32'(wr_count), 32'hFFFF);
`endif

    repeat (4) @(negedge clk);
    check("pending_responses", 32'(expq.size()), 32'd0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
